uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer between the UART receiver (one-cycle byte strobe per received character) and the AHB-lite UART register interface.
- Absorbs bursts of received bytes so firmware polling or IRQ latency does not lose characters.
- Provides level/overflow status and a level-sensitive interrupt request for the processor IRQ vector.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- IRQ_THRESH, 1, irq asserts when count >= IRQ_THRESH; legal range 1..DEPTH.
- TIMEOUT_CYCLES, 50000, idle cycles before timeout IRQ (optional feature only); minimum 2.

Ports:
- clk  input  1  system clock (all logic on rising edge)
- RST  input  1  synchronous reset, active-high
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe: rx_data valid this cycle (push request)
- rd_en  input  1  one-cycle pop request from register interface (data-register read)
- flush  input  1  synchronous clear of contents
- ovf_clr  input  1  clears sticky overflow flag
- rd_data  output  8  head entry (first-word fall-through); 8'h00 when empty
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a byte was dropped
- irq  output  1  level interrupt request

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on RST.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, irq=0, rd_data=8'h00. Storage contents are don't-care.
- Storage: DEPTH x 8 array. Pointers are ADDR_W bits and wrap modulo DEPTH from DEPTH-1 to 0.
- Push: accepted when rx_valid=1 and (full=0 or pop accepted in the same cycle). The byte is written at wr_ptr, then wr_ptr increments.
- Pop: accepted when rd_en=1 and empty=0. rd_ptr increments. rd_data shows the new head the cycle after the pop edge.
- Latency: a byte pushed at edge N is visible on rd_data, with empty=0, after edge N. Zero-cycle bypass is not allowed.
- Simultaneous push+pop:
  - Not empty (including full): both accepted, count unchanged.
  - Empty: the pop is ignored and the push is accepted, so count becomes 1.
- Overflow: rx_valid=1 with full=1 and no accepted pop drops the byte. Contents are unchanged and overflow is set to 1.
- Overflow clear: overflow holds until ovf_clr or RST. If ovf_clr and a new overflow event occur in the same cycle, set wins.
- Underflow: rd_en with empty=1 has no effect on any state.
- flush: sets pointers and count to 0 on the next edge. Any push or pop in the same cycle is discarded. overflow is not affected.
- Priority order: RST > flush > push/pop.
- count, empty, full: registered, updated on the same edge as the pointers.
- irq (registered): 1 when next-state count >= IRQ_THRESH, else 0. OR-ed with timeout_flag when the optional feature is enabled.
- Reset mid-operation: all occupancy is lost and outputs return to reset values on the next edge. Bytes pushed in the reset cycle are discarded.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- Enabled:
  - Adds an idle counter (width sufficient for TIMEOUT_CYCLES). It clears to 0 on any accepted push or pop, on flush, on RST, and while empty=1. Otherwise it increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES-1, timeout_flag is set and the counter saturates.
  - timeout_flag clears on an accepted pop, flush, or RST.
  - irq = threshold condition OR timeout_flag. This catches short messages below IRQ_THRESH.
- Disabled: no counter or flag logic exists; irq is the threshold condition only. The port list is identical in both builds.

Test Plan:
- Reset/basic: assert RST 2 cycles; push 8'hA5 -> next cycle rd_data=8'hA5, count=1, empty=0, irq=1 (IRQ_THRESH=1). Pop -> empty=1, rd_data=8'h00, irq=0.
- Fill/wrap: push 0x00..0x0F (16 bytes) -> full=1, count=16. Pop 4, push 0x10..0x13 -> popped order 0x04..0x13 with correct wrap, full=1 again.
- Overflow: with full=1, push 8'hEE -> overflow=1, count=16, 8'hEE never read. Pulse ovf_clr -> overflow=0. ovf_clr together with another overflow -> overflow stays 1.
- Simultaneous ops: full + push 0x55 + pop -> count stays 16, overflow=0, 0x55 read last. Empty + push 0x66 + pop -> count=1, rd_data=0x66.
- Flush/underflow: 5 bytes held, flush with a concurrent push -> count=0, empty=1. rd_en while empty for 3 cycles -> no state change.
- Timeout (UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_CYCLES=10, IRQ_THRESH=4): push 1 byte, idle -> irq rises 10 cycles after the push. A pop clears irq. Without the macro, irq stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and its register interface.
// Define UART_RX_FIFO_TIMEOUT_EN to add an idle-timeout term to irq.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int IRQ_THRESH     = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              irq
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (1 << ADDR_W) != DEPTH ||
            IRQ_THRESH < 1 || IRQ_THRESH > DEPTH || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("uart_rx_fifo: illegal parameter combination");
        end
    endgenerate

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_irq;

    logic              w_pop;
    logic              w_push;
    logic              w_ovf_evt;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_thresh;
    logic              w_irq_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign w_pop     = rd_en && !r_empty;
    assign w_push    = rx_valid && (!r_full || w_pop);
    assign w_ovf_evt = rx_valid && r_full && !w_pop && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR_W + 1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (ADDR_W + 1)'(1);
        end
    end

    assign w_thresh = (w_count_nxt >= (ADDR_W + 1)'(IRQ_THRESH));

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_idle;
    logic            r_to_flag;
    logic            w_idle_clr;
    logic            w_to_flag_nxt;

    assign w_idle_clr = flush || w_push || w_pop || r_empty;

    always_comb begin
        w_to_flag_nxt = r_to_flag;
        if (flush || w_pop) begin
            w_to_flag_nxt = 1'b0;
        end else if (!w_idle_clr && r_idle == TO_LAST) begin
            w_to_flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_idle    <= '0;
            r_to_flag <= 1'b0;
        end else begin
            r_to_flag <= w_to_flag_nxt;
            if (w_idle_clr) begin
                r_idle <= '0;
            end else if (r_idle != TO_LAST) begin
                r_idle <= r_idle + TO_W'(1);
            end
        end
    end

    assign w_irq_nxt = w_thresh || w_to_flag_nxt;
`else
    assign w_irq_nxt = w_thresh;
`endif

    // Storage has no reset; only occupied entries are ever observable.
    always_ff @(posedge clk) begin
        if (!RST && !flush && w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == (ADDR_W + 1)'(DEPTH));
            r_irq   <= w_irq_nxt;
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data  = r_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign empty    = r_empty;
    assign full     = r_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps then random traffic,
// every cycle compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TO_CYC  = 10;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int THRESH  = 4;
    localparam bit TO_EN   = 1'b1;
`else
    localparam int THRESH  = 1;
    localparam bit TO_EN   = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            RST = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rd_en = 1'b0;
    logic            flush = 1'b0;
    logic            ovf_clr = 1'b0;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            irq;

    uart_rx_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IRQ_THRESH(THRESH), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rd_en(rd_en),
        .flush(flush), .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents as a queue, sticky overflow, idle-time tracking.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_idle = 0;
    bit         m_to = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d,
                              input bit rd, input bit fl, input bit oc);
        bit was_empty, pop, push;
        if (r) begin
            m_q.delete(); m_ovf = 0; m_idle = 0; m_to = 0;
        end else if (fl) begin
            m_q.delete(); m_idle = 0; m_to = 0;
            if (oc) m_ovf = 0;
        end else begin
            was_empty = (m_q.size() == 0);
            pop  = rd && !was_empty;
            push = v && (m_q.size() < DEPTH || pop);
            if (v && m_q.size() == DEPTH && !pop) m_ovf = 1;
            else if (oc) m_ovf = 0;
            if (push || pop || was_empty) m_idle = 0;
            else if (m_idle == TO_CYC - 1) m_to = 1;
            else m_idle++;
            if (pop) begin
                m_to = 0;
                void'(m_q.pop_front());
            end
            if (push) m_q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("rd_data",  32'(rd_data),  n > 0 ? 32'(m_q[0]) : 32'h0);
        check("count",    32'(count),    32'(n));
        check("empty",    32'(empty),    32'(n == 0));
        check("full",     32'(full),     32'(n == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("irq",      32'(irq),      32'((n >= THRESH) || (TO_EN && m_to)));
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                       input bit rd, input bit fl, input bit oc);
        RST = r; rx_valid = v; rx_data = d; rd_en = rd; flush = fl; ovf_clr = oc;
        @(posedge clk);
        model_step(r, v, d, rd, fl, oc);
        #1;
        check_all();
    endtask

    task automatic push(input logic [7:0] d); cyc(0, 1, d, 0, 0, 0); endtask
    task automatic pop();                     cyc(0, 0, 8'h00, 1, 0, 0); endtask
    task automatic idle();                    cyc(0, 0, 8'h00, 0, 0, 0); endtask

    initial begin
        #1;
        // Reset and basic push/pop
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(1, 1, 8'h77, 0, 0, 0);
        check("reset_empty", 32'(empty), 32'h1);
        push(8'hA5);
        check("first_byte", 32'(rd_data), 32'hA5);
        pop();
        check("pop_to_empty", 32'(rd_data), 32'h0);

        // Fill, then wrap the pointers
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_full", 32'(full), 32'h1);
        for (int i = 0; i < 4; i++) pop();
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        check("wrap_full", 32'(count), 32'd16);
        check("wrap_head", 32'(rd_data), 32'h04);

        // Overflow and its clear, including clear colliding with a new drop
        push(8'hEE);
        check("ovf_set", 32'(overflow), 32'h1);
        cyc(0, 0, 8'h00, 0, 0, 1);
        check("ovf_clr", 32'(overflow), 32'h0);
        cyc(0, 1, 8'hEE, 0, 0, 1);
        check("ovf_set_wins", 32'(overflow), 32'h1);
        cyc(0, 0, 8'h00, 0, 0, 1);

        // Full with simultaneous push and pop
        cyc(0, 1, 8'h55, 1, 0, 0);
        check("full_pushpop_cnt", 32'(count), 32'd16);
        check("full_pushpop_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 15; i++) begin
            check("drain_order", 32'(rd_data), 32'(8'h05 + i));
            pop();
        end
        check("last_is_55", 32'(rd_data), 32'h55);
        pop();

        // Empty with simultaneous push and pop: pop ignored
        cyc(0, 1, 8'h66, 1, 0, 0);
        check("empty_pushpop_cnt", 32'(count), 32'd1);
        check("empty_pushpop_data", 32'(rd_data), 32'h66);

        // Flush with a concurrent push, then underflow attempts
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        cyc(0, 1, 8'hDD, 0, 1, 0);
        check("flush_cnt", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) pop();
        check("underflow_empty", 32'(empty), 32'h1);

        // Single byte then idle: irq only via the timeout when enabled
        push(8'h3C);
        for (int i = 1; i <= 12; i++) begin
            idle();
            if (i == 9)  check("irq_before_to", 32'(irq), 32'(THRESH <= 1));
            if (i == 10) check("irq_at_to",     32'(irq), 32'(TO_EN || THRESH <= 1));
        end
        pop();
        check("irq_after_pop", 32'(irq), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit r, v, rd, fl, oc;
            int mode;
            mode = (i / 150) % 3;
            r  = ($urandom_range(0, 299) == 0);
            fl = ($urandom_range(0, 99) == 0);
            oc = ($urandom_range(0, 19) == 0);
            case (mode)
                0:       begin v = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0); end
                1:       begin v = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0); end
                default: begin v = ($urandom_range(0, 7) == 0); rd = ($urandom_range(0, 15) == 0); end
            endcase
            cyc(r, v, 8'($urandom), rd, fl, oc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
